entero_a_fijo: RTL and testbench

Sequential integer-to-fixed-point converter, the inverse path of the fixed-point-to-integer adapter. It takes a 16-bit integer and a 16-bit divisor, usually the wheel circumference constant. It produces the 24-bit Q20.4 value `(entero << 4) / divisor` using serial restoring division, one quotient bit per clock. It sits between the integer counters and the fixed-point arithmetic datapath.

---
 rtl/punto_fijo_pkg.sv | 18 +
 rtl/paso_division.sv | 24 ++
 rtl/entero_a_fijo.sv | 130 +++++++++++++
 tb/tb_entero_a_fijo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/punto_fijo_pkg.sv
// Shared fixed-point defaults, the wheel circumference constant and the
// converter state encoding.
package punto_fijo_pkg;

    localparam int IN_W_DEF      = 16;
    localparam int FRAC_BITS_DEF = 4;
    localparam int OUT_W_DEF     = 24;

    // Default divisor source for the integer-to-fixed conversion
    localparam logic [15:0] CIRCUNFERENCIA = 16'd2326;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

endpackage

// File: rtl/paso_division.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits.
module paso_division #(
    parameter int IN_W = 16
) (
    input  logic [IN_W:0]   resto_i,
    input  logic            bit_i,
    input  logic [IN_W-1:0] divisor_i,
    output logic [IN_W:0]   resto_o,
    output logic            q_o
);

    logic [IN_W+1:0] r;
    logic [IN_W:0]   dif;

    always_comb begin
        r   = {resto_i, bit_i};
        // Only the low IN_W+1 bits of the difference matter: it is < divisor
        dif = r[IN_W:0] - {1'b0, divisor_i};
        q_o = (r >= {2'b00, divisor_i});
        resto_o = q_o ? dif : r[IN_W:0];
    end

endmodule

// File: rtl/entero_a_fijo.sv
// Serial integer -> Q(OUT_W-FRAC_BITS).FRAC_BITS converter, one quotient bit per clock.
// Optional round-half-up build: define ENTERO_A_FIJO_REDONDEO_EN.
module entero_a_fijo
    import punto_fijo_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int OUT_W     = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  entero,
    input  logic [IN_W-1:0]  divisor,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] fixedPoint,
    output logic             div_cero
);

`ifdef ENTERO_A_FIJO_REDONDEO_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif
    localparam int STEPS = IN_W + FRAC_BITS + GUARD;
    localparam int CNT_W = $clog2(STEPS);

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STEPS-1:0] dvd_q, dvd_d;
    logic [STEPS-2:0] quo_q, quo_d;
    logic [IN_W:0]    rem_q, rem_d;
    logic [IN_W-1:0]  div_q, div_d;
    logic [OUT_W-1:0] fp_q, fp_d;
    logic             dz_q, dz_d;

    logic [IN_W:0]    rem_nxt;
    logic             q_bit;
    logic [STEPS-1:0] quo_full;
    logic [OUT_W-1:0] fp_res;

    paso_division #(.IN_W(IN_W)) u_paso (
        .resto_i   (rem_q),
        .bit_i     (dvd_q[STEPS-1]),
        .divisor_i (div_q),
        .resto_o   (rem_nxt),
        .q_o       (q_bit)
    );

    assign quo_full = {quo_q, q_bit};

`ifdef ENTERO_A_FIJO_REDONDEO_EN
    // LSB of quo_full is the guard bit: add it back for round-half-up
    assign fp_res = OUT_W'(quo_full[STEPS-1:1]) + OUT_W'(quo_full[0]);
`else
    assign fp_res = OUT_W'(quo_full);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        fp_d    = fp_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    div_d = divisor;
                    dvd_d = {entero, {(STEPS-IN_W){1'b0}}};
                    quo_d = '0;
                    rem_d = '0;
                    cnt_d = CNT_W'(STEPS-1);
                    dz_d  = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        fp_d    = '1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d = rem_nxt;
                dvd_d = dvd_q << 1;
                quo_d = quo_full[STEPS-2:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    fp_d    = fp_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            fp_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            fp_q    <= fp_d;
            dz_q    <= dz_d;
        end
    end

    assign busy       = (state_q == CALC);
    assign done       = (state_q == DONE);
    assign fixedPoint = fp_q;
    assign div_cero   = dz_q;

endmodule

// File: tb/tb_entero_a_fijo.sv
// Bench for entero_a_fijo: latency/value model checked every cycle plus directed literals.
module tb_entero_a_fijo;
    import punto_fijo_pkg::*;

`ifdef ENTERO_A_FIJO_REDONDEO_EN
    localparam int LAT = 22;
`else
    localparam int LAT = 21;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] entero = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_cero;
    logic [23:0] fixedPoint;

    int chk = 0;
    int errs = 0;

    entero_a_fijo dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .entero     (entero),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .fixedPoint (fixedPoint),
        .div_cero   (div_cero)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_val(input int e, input int d);
        longint n;
        n = longint'(e) * 16;
`ifdef ENTERO_A_FIJO_REDONDEO_EN
        ref_val = 24'((n * 2 / d + 1) / 2);
`else
        ref_val = 24'(n / d);
`endif
    endfunction

    // Model: countdown of remaining busy cycles, result computed arithmetically
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic        m_dz = 1'b0;
    logic [23:0] m_fp = '0;
    logic [23:0] m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_fp   <= '0;
        end else if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) m_fp <= m_pend;
        end else if (start) begin
            m_dz <= (divisor == 0);
            if (divisor == 0) begin
                m_done <= 1'b1;
                m_fp   <= '1;
            end else begin
                m_cnt  <= LAT - 1;
                m_done <= 1'b0;
                m_pend <= ref_val(int'(entero), int'(divisor));
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk++;
        if (busy !== (m_cnt != 0) || done !== m_done || div_cero !== m_dz || fixedPoint !== m_fp) begin
            errs++;
            $display("FAIL model t=%0t got busy=%b done=%b dz=%b fp=%h want busy=%b done=%b dz=%b fp=%h",
                     $time, busy, done, div_cero, fixedPoint, (m_cnt != 0), m_done, m_dz, m_fp);
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        chk++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Issue one op, optionally inject a stray start at CALC cycle inj, then check literals
    task automatic run_op(input string name, input int e, input int d, input int inj,
                          input logic [23:0] exp_fp, input int exp_lat, input logic exp_dz);
        int n;
        @(negedge clk);
        start = 1'b1; entero = 16'(e); divisor = 16'(d);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (n == inj) begin
                start = 1'b1; entero = 16'd9; divisor = 16'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({name, " done"}, longint'(done), 1);
        check({name, " latency"}, n, exp_lat);
        check({name, " value"}, fixedPoint, exp_fp);
        check({name, " div_cero"}, longint'(div_cero), longint'(exp_dz));
    endtask

    initial begin
        int ndone;
        repeat (3) @(negedge clk);
        check("reset busy", longint'(busy), 0);
        check("reset done", longint'(done), 0);
        check("reset fp", fixedPoint, 0);
        check("reset dz", longint'(div_cero), 0);
        #1 rst = 1'b0;

        check("model 100/1", ref_val(100, 1), 24'h000640);
`ifdef ENTERO_A_FIJO_REDONDEO_EN
        check("model 2/3", ref_val(2, 3), 24'h00000B);
`else
        check("model 2/3", ref_val(2, 3), 24'h00000A);
`endif

        run_op("100/1", 100, 1, 0, 24'h000640, LAT, 1'b0);
        run_op("circ", 2326, int'(CIRCUNFERENCIA), 0, 24'h000010, LAT, 1'b0);
        run_op("max", 65535, 1, 0, 24'h0FFFF0, LAT, 1'b0);
`ifdef ENTERO_A_FIJO_REDONDEO_EN
        run_op("2/3", 2, 3, 0, 24'h00000B, LAT, 1'b0);
        run_op("ignored start", 100, 7, 5, 24'h0000E5, LAT, 1'b0);
`else
        run_op("2/3", 2, 3, 0, 24'h00000A, LAT, 1'b0);
        run_op("ignored start", 100, 7, 5, 24'h0000E4, LAT, 1'b0);
`endif
        run_op("div0", 1234, 0, 0, 24'hFFFFFF, 1, 1'b1);
        run_op("after div0", 3, 1, 0, 24'h000030, LAT, 1'b0);

        // Abort mid-CALC with reset
        @(negedge clk);
        start = 1'b1; entero = 16'd50; divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst busy", longint'(busy), 0);
        check("rst done", longint'(done), 0);
        check("rst fp", fixedPoint, 0);
        #1 rst = 1'b0;
        ndone = 0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no done after abort", ndone, 0);
        run_op("post reset", 7, 2, 0, 24'h000038, LAT, 1'b0);

        // start held through DONE: one result every LAT cycles
        @(negedge clk);
        start = 1'b1; entero = 16'd300; divisor = 16'd5;
        ndone = 0;
        repeat (2 * LAT + 5) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("b2b value", fixedPoint, 24'h0003C0);
            end
        end
        start = 1'b0;
        check("b2b count", ndone, 2);
        repeat (LAT + 3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
